osd_regaccess_burst: RTL
========================

// Module: osd_regaccess_burst
// PURPOSE
//  Next-generation status/control register interface for OSD debug modules. Parses DII
//  register-access packets, serves built-in module registers, forwards other addresses to
//  a MAX_REG_SIZE-wide module register port, and returns response packets.
//  Adds 32/64-bit values, burst read/write and an external-access timeout.
// PARAMETERS
//  MODID         'x   module type ID returned by reg 0
//  MODVERSION    'x   module version returned by reg 1
//  MODVENDOR     'x   vendor ID returned by reg 2
//  CAN_STALL     0    1: CS.stall bit writable and drives stall; 0: CS writes error
//  MAX_REG_SIZE  16   16/32/64; widest register value supported
//  MAX_BURST     8    max registers per burst (1..256)
//  REG_TIMEOUT   1024 cycles before an unacked ext access errors; 0 disables
// PORTS
//  clk              in   1    clock
//  rst              in   1    reset, synchronous, active-high
//  id               in   10   own DI address
//  debug_in         in   flit request flits (dii_flit: data[15:0], valid, last)
//  debug_in_ready   out  1    flit accepted when valid&ready
//  debug_out        out  flit response flits
//  debug_out_ready  in   1    sink ready
//  reg_request      out  1    ext access pending; held until ack/err/timeout
//  reg_write        out  1    1=write
//  reg_addr         out  16   ext register address
//  reg_size         out  2    01=16b 10=32b 11=64b
//  reg_wdata        out  MAX_REG_SIZE  write value, right-aligned
//  reg_ack          in   1    access done, reg_rdata valid this cycle
//  reg_err          in   1    access failed
//  reg_rdata        in   MAX_REG_SIZE  read value, right-aligned
//  stall            out  1    CS.stall when CAN_STALL else 0
// BEHAVIOUR
//  Request: F0 dest (ignored); F1 {type[15:14],burst[13],write[12],size[11:10],src[9:0]};
//   F2 addr; burst read: F3 count (0 -> error, >MAX_BURST -> error); writes: data words.
//  Value = W flits, MS flit first, W = 1/2/4 for size 01/10/11.
//  Error conditions: type!=0 -> drop, no response; size 00 or wider than MAX_REG_SIZE;
//   unknown local addr; write to read-only reg; write payload not multiple of W or empty.
//  Local (addr[15:9]==0): 0 MODID, 1 VERSION, 2 VENDOR, 3 CS, 4 MAX_REG_SIZE; all 16-bit.
//   Size must be 01. CS write: data[15:11]==5'h1 sets stall=data[0]; other codes error.
//  External (addr[15:9]!=0): one reg_request per register, 1 cycle after last word taken.
//   reg_addr/reg_size/reg_write/reg_wdata stable while reg_request=1.
//   ack and err same cycle -> err wins. Timeout drops reg_request; treated as err.
//  Burst: address +1 per register (16-bit wrap 0xFFFF->0x0000). Burst write ends at last flit.
//   The first failing register sets error; remaining input is drained without access.
//  Response: R0 {6'h0,src}; R1 {4'h0,write,error,id}, last if write|error; reads add W flits
//   per register, last on final flit.
//  Burst read: register k is accessed before its words are sent. If access k>0 fails,
//   emit one 16'h0000 flit with last=1 and stop (truncated response).
//  States: IDLE, HDR, ADDR, COUNT, WDATA, ACCESS, RESP_DEST, RESP_SRC, RESP_DATA, DROP.
//  debug_in_ready=1 only in IDLE/HDR/ADDR/COUNT/WDATA/DROP; 0 in ACCESS and RESP_*.
//   Back-pressure via debug_out_ready holds the current flit unchanged.
//  Single write latency: last data flit -> R0 valid in >=2 cycles (local exactly 2).
//  Reset: state IDLE; debug_in_ready, debug_out.valid and reg_request are 0 while rst=1;
//   stall=1 if CAN_STALL. A reset mid-packet abandons it; the rest of the packet is parsed
//   as new packets by the upstream owner's contract.
// TESTING
//  Read 16b addr 0, MODID=5 -> R0=src, R1={4'h0,0,0,id}, R2=0x0005 last.
//  Write CS data 0x0800, CAN_STALL=1 -> stall 1->0, R1 write=1 err=0 last.
//  MAX_REG_SIZE=64, read 64b ext 0x0200, rdata=0x1122334455667788 -> 0x1122,0x3344,0x5566,0x7788.
//  Burst read ext 0x0200 count 3, reg_err on 2nd -> data words of reg0, then 0x0000 last.
//  Ext write, no ack, REG_TIMEOUT=16 -> reg_request drops after 16 cycles, R1 err=1.
//  Read 32b local addr 0 -> error response; type=2'b01 -> dropped, no output; rst mid-burst -> IDLE.

Source files
------------

// File: rtl/osd_regaccess_burst.sv
// Register-access endpoint for OSD debug modules. Parses DII register-access
// packets (single or burst, 16/32/64-bit values), serves the built-in registers
// locally, forwards all other addresses to the module register port, and
// returns a response packet. Flits are packed as {data[15:0], valid, last}.
module osd_regaccess_burst #(
  parameter logic [15:0] MODID        = 16'h0000,
  parameter logic [15:0] MODVERSION   = 16'h0000,
  parameter logic [15:0] MODVENDOR    = 16'h0000,
  parameter bit          CAN_STALL    = 1'b0,
  parameter int unsigned MAX_REG_SIZE = 16,
  parameter int unsigned MAX_BURST    = 8,
  parameter int unsigned REG_TIMEOUT  = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [9:0]              id,
  input  logic [17:0]             debug_in,
  output logic                    debug_in_ready,
  output logic [17:0]             debug_out,
  input  logic                    debug_out_ready,
  output logic                    reg_request,
  output logic                    reg_write,
  output logic [15:0]             reg_addr,
  output logic [1:0]              reg_size,
  output logic [MAX_REG_SIZE-1:0] reg_wdata,
  input  logic                    reg_ack,
  input  logic                    reg_err,
  input  logic [MAX_REG_SIZE-1:0] reg_rdata,
  output logic                    stall
);

  typedef enum logic [3:0] {
    StIdle, StHdr, StAddr, StCount, StWdata, StAccess,
    StRespDest, StRespSrc, StRespData, StDrop
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  src_q, src_d;
  logic        burst_q, burst_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic [15:0] addr_q, addr_d;
  logic [8:0]  count_q, count_d;      // registers requested (reads)
  logic [8:0]  reg_cnt_q, reg_cnt_d;  // registers completed so far
  logic [1:0]  wcnt_q, wcnt_d;        // word index within current value
  logic [63:0] data_q, data_d;        // writes: right-aligned; reads: left-aligned
  logic        error_q, error_d;
  logic        trunc_q, trunc_d;      // burst read aborted after first register
  logic        last_seen_q, last_seen_d;
  logic [31:0] tmo_q, tmo_d;
  logic        stall_q, stall_d;

  logic [15:0] in_data;
  logic        in_valid, in_last;
  logic [15:0] out_data;
  logic        out_valid, out_last;
  logic [1:0]  w_last;
  logic        size_ok, acc_local, acc_bad, acc_done, acc_fail, timeout_hit, cnt_bad;
  logic [15:0] loc_val;
  logic [63:0] rdata64, rd_aligned;

  assign {in_data, in_valid, in_last} = debug_in;
  assign debug_out = {out_data, out_valid, out_last};
  assign reg_write = write_q;
  assign reg_addr  = addr_q;
  assign reg_size  = size_q;
  assign reg_wdata = data_q[MAX_REG_SIZE-1:0];
  assign stall     = CAN_STALL ? stall_q : 1'b0;
  assign rdata64   = 64'(reg_rdata);

  // Value geometry, local register file and external read alignment
  always_comb begin
    unique case (size_q)
      2'b10:   w_last = 2'd1;
      2'b11:   w_last = 2'd3;
      default: w_last = 2'd0;
    endcase
    size_ok = (size_q == 2'b01) ||
              (size_q == 2'b10 && MAX_REG_SIZE >= 32) ||
              (size_q == 2'b11 && MAX_REG_SIZE >= 64);
    unique case (size_q)
      2'b10:   rd_aligned = rdata64 << 32;
      2'b11:   rd_aligned = rdata64;
      default: rd_aligned = rdata64 << 48;
    endcase
    case (addr_q[2:0])
      3'd0:    loc_val = MODID;
      3'd1:    loc_val = MODVERSION;
      3'd2:    loc_val = MODVENDOR;
      3'd3:    loc_val = {15'h0, stall_q};
      3'd4:    loc_val = 16'(MAX_REG_SIZE);
      default: loc_val = 16'h0000;
    endcase
    acc_local = (addr_q[15:9] == 7'h00);
    // Local regs are 16-bit only; only CS is writable, and only with command code 1
    acc_bad = !size_ok ||
              (acc_local && (size_q != 2'b01 || addr_q[8:0] > 9'd4 ||
               (write_q && (addr_q[8:0] != 9'd3 || !CAN_STALL || data_q[15:11] != 5'h01))));
    timeout_hit = (REG_TIMEOUT != 0) && (tmo_q == REG_TIMEOUT - 1);
  end

  // Packet parser, register access sequencer and response generator
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    burst_d     = burst_q;
    write_d     = write_q;
    size_d      = size_q;
    addr_d      = addr_q;
    count_d     = count_q;
    reg_cnt_d   = reg_cnt_q;
    wcnt_d      = wcnt_q;
    data_d      = data_q;
    error_d     = error_q;
    trunc_d     = trunc_q;
    last_seen_d = last_seen_q;
    tmo_d       = tmo_q;
    stall_d     = stall_q;
    debug_in_ready = 1'b0;
    out_data    = 16'h0000;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    reg_request = 1'b0;
    acc_done    = 1'b0;
    acc_fail    = 1'b0;
    cnt_bad     = (in_data == 16'h0000) || (32'(in_data) > MAX_BURST);

    unique case (state_q)
      StIdle: begin
        debug_in_ready = 1'b1;
        if (in_valid) begin
          error_d     = 1'b0;
          trunc_d     = 1'b0;
          reg_cnt_d   = 9'd0;
          wcnt_d      = 2'd0;
          tmo_d       = 32'd0;
          last_seen_d = 1'b0;
          count_d     = 9'd1;
          if (!in_last) state_d = StHdr;
        end
      end
      StHdr: begin
        debug_in_ready = 1'b1;
        if (in_valid) begin
          src_d   = in_data[9:0];
          size_d  = in_data[11:10];
          write_d = in_data[12];
          burst_d = in_data[13];
          if (in_last)                     state_d = StIdle;
          else if (in_data[15:14] != 2'b00) state_d = StDrop;
          else                             state_d = StAddr;
        end
      end
      StAddr: begin
        debug_in_ready = 1'b1;
        if (in_valid) begin
          addr_d = in_data;
          if (write_q || burst_q) begin
            // Writes need payload, burst reads need a count
            if (in_last) begin
              error_d = 1'b1;
              state_d = StRespDest;
            end else begin
              state_d = write_q ? StWdata : StCount;
            end
          end else if (in_last) begin
            state_d = StAccess;
          end else begin
            error_d = 1'b1;
            state_d = StWdata;
          end
        end
      end
      StCount: begin
        debug_in_ready = 1'b1;
        if (in_valid) begin
          count_d = in_data[8:0];
          if (cnt_bad || !in_last) error_d = 1'b1;
          if (!in_last)     state_d = StWdata;
          else if (cnt_bad) state_d = StRespDest;
          else              state_d = StAccess;
        end
      end
      StWdata: begin
        debug_in_ready = 1'b1;
        if (in_valid) begin
          if (error_q) begin
            // Drain the rest of the packet without touching registers
            if (in_last) state_d = StRespDest;
          end else begin
            data_d = (wcnt_q == 2'd0) ? {48'h0, in_data} : {data_q[47:0], in_data};
            if (wcnt_q == w_last) begin
              wcnt_d = 2'd0;
              if ((!burst_q && !in_last) || 32'(reg_cnt_q) >= MAX_BURST) begin
                error_d = 1'b1;
                if (in_last) state_d = StRespDest;
              end else begin
                last_seen_d = in_last;
                state_d     = StAccess;
              end
            end else begin
              wcnt_d = wcnt_q + 2'd1;
              if (in_last) begin
                error_d = 1'b1;
                state_d = StRespDest;
              end
            end
          end
        end
      end
      StAccess: begin
        if (acc_bad) begin
          acc_fail = 1'b1;
        end else if (acc_local) begin
          acc_done = 1'b1;
          if (write_q) stall_d = data_q[0];
          else         data_d  = {loc_val, 48'h0};
        end else begin
          reg_request = 1'b1;
          if (reg_err) begin
            acc_fail = 1'b1;
          end else if (reg_ack) begin
            acc_done = 1'b1;
            if (!write_q) data_d = rd_aligned;
          end else if (timeout_hit) begin
            acc_fail = 1'b1;
          end else begin
            tmo_d = tmo_q + 32'd1;
          end
        end
        if (acc_done || acc_fail) begin
          tmo_d  = 32'd0;
          wcnt_d = 2'd0;
          if (write_q)                state_d = last_seen_q ? StRespDest : StWdata;
          else if (reg_cnt_q == 9'd0) state_d = StRespDest;
          else begin
            state_d = StRespData;
            trunc_d = acc_fail;
          end
        end
        if (acc_done) begin
          addr_d    = addr_q + 16'd1;
          reg_cnt_d = reg_cnt_q + 9'd1;
        end
        if (acc_fail) error_d = 1'b1;
      end
      StRespDest: begin
        out_valid = 1'b1;
        out_data  = {6'h00, src_q};
        if (debug_out_ready) state_d = StRespSrc;
      end
      StRespSrc: begin
        out_valid = 1'b1;
        out_data  = {4'h0, write_q, error_q, id};
        out_last  = write_q || error_q;
        if (debug_out_ready) state_d = out_last ? StIdle : StRespData;
      end
      StRespData: begin
        out_valid = 1'b1;
        if (trunc_q) begin
          out_last = 1'b1;
          if (debug_out_ready) state_d = StIdle;
        end else begin
          out_data = data_q[63:48];
          out_last = (wcnt_q == w_last) && (reg_cnt_q == count_q);
          if (debug_out_ready) begin
            data_d = {data_q[47:0], 16'h0000};
            if (wcnt_q == w_last) begin
              wcnt_d  = 2'd0;
              state_d = out_last ? StIdle : StAccess;
            end else begin
              wcnt_d = wcnt_q + 2'd1;
            end
          end
        end
      end
      StDrop: begin
        debug_in_ready = 1'b1;
        if (in_valid && in_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (rst) begin
      debug_in_ready = 1'b0;
      out_valid      = 1'b0;
      reg_request    = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      src_q       <= 10'h000;
      burst_q     <= 1'b0;
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= 16'h0000;
      count_q     <= 9'd0;
      reg_cnt_q   <= 9'd0;
      wcnt_q      <= 2'd0;
      data_q      <= 64'h0;
      error_q     <= 1'b0;
      trunc_q     <= 1'b0;
      last_seen_q <= 1'b0;
      tmo_q       <= 32'd0;
      stall_q     <= CAN_STALL;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      burst_q     <= burst_d;
      write_q     <= write_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      reg_cnt_q   <= reg_cnt_d;
      wcnt_q      <= wcnt_d;
      data_q      <= data_d;
      error_q     <= error_d;
      trunc_q     <= trunc_d;
      last_seen_q <= last_seen_d;
      tmo_q       <= tmo_d;
      stall_q     <= stall_d;
    end
  end

endmodule
